decim_mc: RTL and testbench

- Multi-channel, parametrised decimator for the radar ADC sample path. Successor to the single-channel pick-every-Nth down-sampler.
- Accepts one frame per beat, carrying NUM_CH parallel signed samples.
- Emits one frame per decimation group of PSC input frames. Two modes: pick (last sample of the group) or boxcar average (accumulate, then arithmetic shift).
- Adds valid/ready output backpressure, sticky overflow, a synchronous clear, and safe handling of PSC=0.

---
 rtl/decim_pkg.sv | 31 +++
 rtl/decim_lane.sv | 73 +++++++
 rtl/decim_mc.sv | 132 +++++++++++++
 tb/tb_decim_mc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/decim_pkg.sv
// Shared constants and helpers for the multi-channel decimator.
// Saturation works on a 64-bit signed value so any DATA_W/ACC_W pairing can use it.
package decim_pkg;

   localparam int DATA_W_DEF  = 13;
   localparam int NUM_CH_DEF  = 4;
   localparam int PSC_W_DEF   = 16;
   localparam int SHIFT_W_DEF = 5;
   localparam int SAT_W       = 64;

   localparam logic MODE_PICK = 1'b0;
   localparam logic MODE_AVG  = 1'b1;

   function automatic logic signed [SAT_W-1:0] sat_signed(
      input logic signed [SAT_W-1:0] value,
      input int unsigned             data_w
   );
      logic signed [SAT_W-1:0] hi_v;
      logic signed [SAT_W-1:0] lo_v;
      hi_v = (64'sd1 <<< (data_w - 32'd1)) - 64'sd1;
      lo_v = -hi_v - 64'sd1;
      if (value > hi_v) begin
         return hi_v;
      end else if (value < lo_v) begin
         return lo_v;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/decim_lane.sv
// One channel of the decimator: group accumulator, shift/saturate and sticky overflow.
// The group result is combinational; the top level registers it on group completion.
module decim_lane
   import decim_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SHIFT_W = SHIFT_W_DEF,
   parameter int ACC_W   = DATA_W_DEF + PSC_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear_i,
   input  logic                      beat_i,
   input  logic                      first_i,
   input  logic                      done_i,
   input  logic                      mode_i,
   input  logic [SHIFT_W-1:0]        shift_i,
   input  logic signed [DATA_W-1:0]  sample_i,
   output logic signed [DATA_W-1:0]  result_o,
   output logic                      ovf_o
);

   logic signed [ACC_W-1:0] acc_r;
   logic signed [ACC_W-1:0] sample_ext_s;
   logic signed [ACC_W-1:0] sum_s;
   logic signed [ACC_W-1:0] shifted_s;
   logic signed [SAT_W-1:0] wide_s;
   logic signed [SAT_W-1:0] sat_s;
   logic                    sat_hit_s;
   logic                    ovf_r;

   assign sample_ext_s = {{(ACC_W-DATA_W){sample_i[DATA_W-1]}}, sample_i};

   // Running sum including the current beat, then the average shift and clamp.
   always_comb begin
      sum_s = sample_ext_s;
      if (first_i) begin
         sum_s = sample_ext_s;
      end else begin
         sum_s = acc_r + sample_ext_s;
      end
      shifted_s = sum_s >>> shift_i;
      wide_s    = {{(SAT_W-ACC_W){shifted_s[ACC_W-1]}}, shifted_s};
      sat_s     = sat_signed(wide_s, DATA_W);
      sat_hit_s = (sat_s != wide_s);
      if (mode_i == MODE_AVG) begin
         result_o = sat_s[DATA_W-1:0];
      end else begin
         result_o = sample_i;
      end
   end

   // Accumulator and sticky overflow; clear wins over any beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {ACC_W{1'b0}};
         ovf_r <= 1'b0;
      end else if (clear_i) begin
         acc_r <= {ACC_W{1'b0}};
         ovf_r <= 1'b0;
      end else begin
         if (beat_i) begin
            acc_r <= sum_s;
         end
         if (done_i && (mode_i == MODE_AVG) && sat_hit_s) begin
            ovf_r <= 1'b1;
         end
      end
   end

   assign ovf_o = ovf_r;

endmodule

// File: rtl/decim_mc.sv
// Multi-channel decimator top: group counter, shadowed config, output handshake.
// Config is latched on the first beat of a group so mid-group changes apply to the next group.
module decim_mc
   import decim_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int NUM_CH  = NUM_CH_DEF,
   parameter int PSC_W   = PSC_W_DEF,
   parameter int SHIFT_W = SHIFT_W_DEF,
   parameter int ACC_W   = DATA_W + PSC_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear_i,
   input  logic [PSC_W-1:0]           psc_i,
   input  logic                       mode_i,
   input  logic [SHIFT_W-1:0]         shift_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [NUM_CH*DATA_W-1:0]   in_data_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [NUM_CH*DATA_W-1:0]   out_data_o,
   output logic                       overflow_o
);

   localparam logic [PSC_W-1:0] PSC_ZERO = {PSC_W{1'b0}};
   localparam logic [PSC_W-1:0] PSC_ONE  = {{(PSC_W-1){1'b0}}, 1'b1};

   logic [PSC_W-1:0]         cnt_r;
   logic [PSC_W-1:0]         psc_sh_r;
   logic                     mode_sh_r;
   logic [SHIFT_W-1:0]       shift_sh_r;
   logic                     out_valid_r;
   logic [NUM_CH*DATA_W-1:0] out_data_r;

   logic [PSC_W-1:0]         psc_cur_s;
   logic                     mode_cur_s;
   logic [SHIFT_W-1:0]       shift_cur_s;
   logic                     beat_s;
   logic                     first_s;
   logic                     last_s;
   logic                     done_s;
   logic [NUM_CH*DATA_W-1:0] lane_data_s;
   logic [NUM_CH-1:0]        ovf_vec_s;

   assign in_ready_o = !out_valid_r || out_ready_i;
   assign beat_s     = in_valid_i && in_ready_o && !clear_i;
   assign first_s    = (cnt_r == PSC_ZERO);

   // Effective config for this beat: live inputs at group start, shadow otherwise.
   always_comb begin
      psc_cur_s   = psc_sh_r;
      mode_cur_s  = mode_sh_r;
      shift_cur_s = shift_sh_r;
      if (first_s) begin
         if (psc_i == PSC_ZERO) begin
            psc_cur_s = PSC_ONE;
         end else begin
            psc_cur_s = psc_i;
         end
         mode_cur_s  = mode_i;
         shift_cur_s = shift_i;
      end else begin
         psc_cur_s   = psc_sh_r;
         mode_cur_s  = mode_sh_r;
         shift_cur_s = shift_sh_r;
      end
      last_s = (cnt_r == (psc_cur_s - PSC_ONE));
      done_s = beat_s && last_s;
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      decim_lane #(
         .DATA_W  (DATA_W),
         .SHIFT_W (SHIFT_W),
         .ACC_W   (ACC_W)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .clear_i  (clear_i),
         .beat_i   (beat_s),
         .first_i  (first_s),
         .done_i   (done_s),
         .mode_i   (mode_cur_s),
         .shift_i  (shift_cur_s),
         .sample_i (in_data_i[k*DATA_W +: DATA_W]),
         .result_o (lane_data_s[k*DATA_W +: DATA_W]),
         .ovf_o    (ovf_vec_s[k])
      );
   end

   // Counter, shadow config and output register with valid/ready handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= PSC_ZERO;
         psc_sh_r    <= PSC_ZERO;
         mode_sh_r   <= MODE_PICK;
         shift_sh_r  <= {SHIFT_W{1'b0}};
         out_valid_r <= 1'b0;
         out_data_r  <= {(NUM_CH*DATA_W){1'b0}};
      end else if (clear_i) begin
         cnt_r       <= PSC_ZERO;
         out_valid_r <= 1'b0;
         out_data_r  <= {(NUM_CH*DATA_W){1'b0}};
      end else begin
         if (beat_s) begin
            if (last_s) begin
               cnt_r <= PSC_ZERO;
            end else begin
               cnt_r <= cnt_r + PSC_ONE;
            end
            if (first_s) begin
               psc_sh_r   <= psc_cur_s;
               mode_sh_r  <= mode_i;
               shift_sh_r <= shift_i;
            end
         end
         if (done_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= lane_data_s;
         end else if (out_ready_i) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign out_valid_o = out_valid_r;
   assign out_data_o  = out_data_r;
   assign overflow_o  = |ovf_vec_s;

endmodule

// File: tb/tb_decim_mc.sv
// Scoreboard bench for decim_mc: a group-level reference model queues expected frames,
// a negedge monitor checks handshake, held data, overflow and popped outputs.
module tb_decim_mc;

   localparam int DW = 13;
   localparam int NC = 4;
   localparam int PW = 16;
   localparam int SW = 5;

   typedef logic [NC*DW-1:0] frame_t;

   logic          clk;
   logic          rst_n;
   logic          clear_i;
   logic [PW-1:0] psc_i;
   logic          mode_i;
   logic [SW-1:0] shift_i;
   logic          in_valid_i;
   logic          in_ready_o;
   frame_t        in_data_i;
   logic          out_valid_o;
   logic          out_ready_i;
   frame_t        out_data_o;
   logic          overflow_o;

   decim_mc #(.DATA_W(DW), .NUM_CH(NC), .PSC_W(PW), .SHIFT_W(SW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (clear_i),
      .psc_i       (psc_i),
      .mode_i      (mode_i),
      .shift_i     (shift_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .overflow_o  (overflow_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int     n_checks = 0;
   int     n_fail   = 0;
   bit     mon_en   = 1'b0;
   frame_t grp_q[$];
   frame_t sb_q[$];
   int     g_psc;
   bit     g_mode;
   int     g_shift;
   bit     model_ovf = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: pick = last frame of the group; average = floor(sum / 2^shift), clamped.
   function automatic frame_t expect_group();
      frame_t r;
      r = '0;
      for (int k = 0; k < NC; k++) begin
         if (!g_mode) begin
            r[k*DW +: DW] = grp_q[grp_q.size()-1][k*DW +: DW];
         end else begin
            longint s;
            logic signed [DW-1:0] smp;
            s = 0;
            foreach (grp_q[i]) begin
               smp = grp_q[i][k*DW +: DW];
               s += smp;
            end
            s = s >>> g_shift;
            if (s > 4095) begin
               s = 4095;
               model_ovf = 1'b1;
            end else if (s < -4096) begin
               s = -4096;
               model_ovf = 1'b1;
            end
            r[k*DW +: DW] = s[DW-1:0];
         end
      end
      return r;
   endfunction

   task automatic model_flush();
      grp_q.delete();
      sb_q.delete();
      model_ovf = 1'b0;
   endtask

   task automatic model_step();
      if (!rst_n || clear_i) begin
         model_flush();
      end else if (in_valid_i && in_ready_o) begin
         if (grp_q.size() == 0) begin
            g_psc   = (psc_i == 0) ? 1 : int'(psc_i);
            g_mode  = mode_i;
            g_shift = int'(shift_i);
         end
         grp_q.push_back(in_data_i);
         if (grp_q.size() == g_psc) begin
            sb_q.push_back(expect_group());
            grp_q.delete();
         end
      end
   endtask

   task automatic beat(input bit v, input frame_t d, input int psc, input bit mode,
                       input int sh, input bit rdy, input bit clr);
      @(posedge clk);
      #1;
      in_valid_i  = v;
      in_data_i   = d;
      psc_i       = psc[PW-1:0];
      mode_i      = mode;
      shift_i     = sh[SW-1:0];
      out_ready_i = rdy;
      clear_i     = clr;
      #7;
      model_step();
   endtask

   function automatic frame_t mk(input int c0, input int c1, input int c2, input int c3);
      frame_t f;
      f = {c3[DW-1:0], c2[DW-1:0], c1[DW-1:0], c0[DW-1:0]};
      return f;
   endfunction

   function automatic frame_t rnd_frame();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[NC*DW-1:0];
   endfunction

   // Monitor: sampled on the falling edge, away from the active edge.
   frame_t held_data;
   bit     stall_prev = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         check("in_ready", 64'(in_ready_o), 64'(!out_valid_o || out_ready_i));
         check("out_valid", 64'(out_valid_o), 64'(sb_q.size() != 0));
         check("overflow", 64'(overflow_o), 64'(model_ovf));
         if (stall_prev && rst_n) begin
            check("held_data", 64'(out_data_o), 64'(held_data));
         end
         if (out_valid_o && out_ready_i && !clear_i && rst_n && sb_q.size() != 0) begin
            frame_t e;
            e = sb_q.pop_front();
            check("out_data", 64'(out_data_o), 64'(e));
         end
         stall_prev = out_valid_o && !out_ready_i && !clear_i && rst_n;
         held_data  = out_data_o;
      end
   end

   initial begin
      rst_n       = 1'b0;
      clear_i     = 1'b0;
      psc_i       = '0;
      mode_i      = 1'b0;
      shift_i     = '0;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      out_ready_i = 1'b1;
      #12;
      check("rst_out_valid", 64'(out_valid_o), 64'd0);
      check("rst_out_data", 64'(out_data_o), 64'd0);
      check("rst_overflow", 64'(overflow_o), 64'd0);
      check("rst_in_ready", 64'(in_ready_o), 64'd1);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Pick, psc=4, ramp on ch0
      for (int i = 0; i < 16; i++) beat(1'b1, mk(i, 100 + i, -i, 7), 4, 1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) beat(1'b0, '0, 4, 1'b0, 0, 1'b1, 1'b0);

      // Average of constant -100
      for (int i = 0; i < 8; i++) beat(1'b1, mk(-100, -100, -100, -100), 4, 1'b1, 2, 1'b1, 1'b0);

      // Saturating average; overflow must stick until clear
      for (int i = 0; i < 8; i++) beat(1'b1, mk(4095, 4095, 4095, 4095), 8, 1'b1, 0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) beat(1'b0, '0, 8, 1'b1, 0, 1'b1, 1'b0);
      check("ovf_sticky", 64'(overflow_o), 64'd1);
      beat(1'b0, '0, 8, 1'b1, 0, 1'b1, 1'b1);

      // Bypass with psc 0 and 1
      for (int i = 0; i < 5; i++) beat(1'b1, rnd_frame(), 0, 1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) beat(1'b1, rnd_frame(), 1, 1'b0, 0, 1'b1, 1'b0);

      // Backpressure: output stalled for 10 cycles with input still offered
      for (int i = 0; i < 2; i++) beat(1'b1, rnd_frame(), 2, 1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) beat(1'b1, rnd_frame(), 2, 1'b0, 0, 1'b0, 1'b0);
      check("stall_in_ready", 64'(in_ready_o), 64'd0);
      for (int i = 0; i < 6; i++) beat(1'b1, rnd_frame(), 2, 1'b0, 0, 1'b1, 1'b0);

      // psc 4 -> 2 after beat 2, then clear mid-group
      for (int i = 0; i < 2; i++) beat(1'b1, rnd_frame(), 4, 1'b1, 1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) beat(1'b1, rnd_frame(), 2, 1'b1, 1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) beat(1'b1, rnd_frame(), 4, 1'b0, 0, 1'b1, 1'b0);
      beat(1'b1, rnd_frame(), 4, 1'b0, 0, 1'b1, 1'b1);
      check("clear_out_valid", 64'(out_valid_o), 64'd0);
      for (int i = 0; i < 4; i++) beat(1'b1, rnd_frame(), 4, 1'b0, 0, 1'b1, 1'b0);

      // Reset mid-group discards the partial group
      for (int i = 0; i < 2; i++) beat(1'b1, rnd_frame(), 4, 1'b1, 0, 1'b1, 1'b0);
      rst_n = 1'b0;
      model_flush();
      beat(1'b0, '0, 4, 1'b0, 0, 1'b1, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) beat(1'b1, rnd_frame(), 4, 1'b0, 0, 1'b1, 1'b0);

      // Randomised traffic with config churn, backpressure and occasional clear
      for (int i = 0; i < 400; i++) begin
         beat($urandom_range(0, 3) != 0, rnd_frame(), int'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
              $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
      end

      for (int i = 0; i < 5; i++) beat(1'b0, '0, 1, 1'b0, 0, 1'b1, 1'b0);
      check("drain_empty", 64'(sb_q.size()), 64'd0);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
